// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request handshake and data-memory bus of the memory-stage controller.
// The controller takes the slave view; the pipeline/memory environment takes the master view.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_halt;
  logic              stall;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_in;
  logic              mem_read;
  logic              mem_write;
  logic              mem_dump;
  logic [DATA_W-1:0] mem_out;
  logic              mem_done;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_halt, mem_out, mem_done,
    output stall, rdata, rdata_valid, err, err_code,
           mem_addr, mem_in, mem_read, mem_write, mem_dump
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_halt, mem_out, mem_done,
    input  stall, rdata, rdata_valid, err, err_code,
           mem_addr, mem_in, mem_read, mem_write, mem_dump
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage request controller: one load/store per handshake, single-cycle strobes,
// stall until mem_done or timeout, alignment check and one-shot dump on halt.
module mem_access_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT     = 15,
  parameter int ALIGN_CHECK = 1
) (
  input logic             clk,
  input logic             rst,
  mem_access_ctrl_if.slave bus
);
  localparam int              CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DUMP, HALTED} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              write_q;
  logic [1:0]        err_code_q;
  logic [CNT_W-1:0]  cnt;
  logic              rd_q, wr_q, dump_q, rv_q, err_q;
  logic              misaligned;

  assign misaligned = (ALIGN_CHECK != 0) && bus.req_addr[0];

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rv_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_in      = wdata_q;
  assign bus.mem_read    = rd_q;
  assign bus.mem_write   = wr_q;
  assign bus.mem_dump    = dump_q;

  always_comb begin
    bus.stall = 1'b1;
    case (state)
      IDLE:    bus.stall = bus.req_halt || (bus.req_valid && !misaligned);
      DONE:    bus.stall = 1'b0;
      default: bus.stall = 1'b1;
    endcase
  end

  // Pulse outputs are set on the transition into the state that owns them,
  // so they come straight off flops and last exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      write_q    <= 1'b0;
      err_code_q <= '0;
      cnt        <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      dump_q     <= 1'b0;
      rv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      dump_q <= 1'b0;
      rv_q   <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_halt) begin
            state  <= DUMP;
            dump_q <= 1'b1;
          end else if (bus.req_valid) begin
            if (misaligned) begin
              err_q      <= 1'b1;
              err_code_q <= 2'b01;
            end else begin
              addr_q  <= bus.req_addr;
              wdata_q <= bus.req_wdata;
              write_q <= bus.req_write;
              rd_q    <= !bus.req_write;
              wr_q    <= bus.req_write;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt <= '0;
          if (bus.mem_done) begin
            state <= DONE;
            if (!write_q) begin
              rdata_q <= bus.mem_out;
              rv_q    <= 1'b1;
            end
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_done) begin
            state <= DONE;
            if (!write_q) begin
              rdata_q <= bus.mem_out;
              rv_q    <= 1'b1;
            end
          end else begin
            if (cnt != TMO) cnt <= cnt + CNT_W'(1);
            if (cnt + CNT_W'(1) == TMO) begin
              state      <= DONE;
              err_q      <= 1'b1;
              err_code_q <= 2'b10;
            end
          end
        end
        DONE:    state <= IDLE;
        DUMP:    state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
